// File: rtl/sync_mon_pkg.sv
// Shared types and constants for the synchronizer error monitor.
package sync_mon_pkg;

  localparam int W_DEF   = 4;
  localparam int CW_DEF  = 16;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [2:0] SEL_SCNT_LO   = 3'd0;
  localparam logic [2:0] SEL_SCNT_HI   = 3'd1;
  localparam logic [2:0] SEL_ECNT_LO   = 3'd2;
  localparam logic [2:0] SEL_ECNT_HI   = 3'd3;
  localparam logic [2:0] SEL_PAIR      = 3'd4;
  localparam logic [2:0] SEL_MAX_BURST = 3'd5;
  localparam logic [2:0] SEL_STATUS    = 3'd6;
  localparam logic [2:0] SEL_PREV      = 3'd7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Exposes the value it will hold
// after the coming edge so callers can act on the post-update count.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;

endmodule

// File: rtl/sync_error_monitor.sv
// Checks captured counter samples for a constant step and keeps error statistics
// behind a registered byte-wide readout mux.
module sync_error_monitor
  import sync_mon_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  input  logic [W-1:0] cfg_delta,
  input  logic         run_en,
  input  logic         clear,
  input  logic [2:0]   sel,
  output logic [7:0]   rd_data,
  output logic         err_pulse,
  output logic [1:0]   state,
  output logic         halted
);

  state_e state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] last_bad_q, last_bad_d;
  logic [W-1:0] last_exp_q, last_exp_d;
  logic [BURST_W-1:0] max_burst_q, max_burst_d;
  logic err_pulse_q, err_pulse_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [CW-1:0]      sample_count_d;
  logic [CW-1:0]      err_count_d;
  logic [BURST_W-1:0] cur_burst_d;
  logic [W-1:0]       expected;
  logic accept, run_take, mismatch;

  // Samples only count while enabled in SEED/RUN; clear suppresses everything.
  assign accept   = sample_valid && run_en && !clear &&
                    ((state_q == ST_SEED) || (state_q == ST_RUN));
  assign run_take = accept && (state_q == ST_RUN);
  assign expected = prev_q + cfg_delta;
  assign mismatch = run_take && (sample != expected);

  sat_counter #(.WIDTH(CW)) u_sample_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(accept), .count_next(sample_count_d)
  );

  sat_counter #(.WIDTH(CW)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(mismatch), .count_next(err_count_d)
  );

  sat_counter #(.WIDTH(BURST_W)) u_burst_cnt (
    .clk(clk), .rst(rst), .clr(clear || (run_take && !mismatch)), .inc(mismatch),
    .count_next(cur_burst_d)
  );

  always_comb begin
    prev_d      = prev_q;
    last_bad_d  = last_bad_q;
    last_exp_d  = last_exp_q;
    max_burst_d = max_burst_q;
    err_pulse_d = mismatch;
    if (clear) begin
      prev_d      = '0;
      last_bad_d  = '0;
      last_exp_d  = '0;
      max_burst_d = '0;
    end else begin
      if (accept) prev_d = sample;
      if (mismatch) begin
        last_bad_d = sample;
        last_exp_d = expected;
      end
      if (run_take && (cur_burst_d > max_burst_q)) max_burst_d = cur_burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (run_en) state_d = ST_SEED;
        ST_SEED: begin
          if (!run_en) state_d = ST_IDLE;
          else if (sample_valid) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!run_en) state_d = ST_IDLE;
          else if (sample_valid && (sample_count_d == '1)) state_d = ST_HALT;
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  // The readout shows statistics as they stand after the edge that samples sel.
  always_comb begin
    rd_data_d = 8'h00;
    case (sel)
      SEL_SCNT_LO:   rd_data_d = 8'(sample_count_d);
      SEL_SCNT_HI:   rd_data_d = 8'(sample_count_d >> 8);
      SEL_ECNT_LO:   rd_data_d = 8'(err_count_d);
      SEL_ECNT_HI:   rd_data_d = 8'(err_count_d >> 8);
      SEL_PAIR:      rd_data_d = 8'({last_exp_d, last_bad_d});
      SEL_MAX_BURST: rd_data_d = max_burst_d;
      SEL_STATUS:    rd_data_d = {4'b0000, state_d, (state_d == ST_HALT), run_en};
      default:       rd_data_d = 8'(prev_d);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      last_bad_q  <= '0;
      last_exp_q  <= '0;
      max_burst_q <= '0;
      err_pulse_q <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      last_bad_q  <= last_bad_d;
      last_exp_q  <= last_exp_d;
      max_burst_q <= max_burst_d;
      err_pulse_q <= err_pulse_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign err_pulse = err_pulse_q;
  assign state     = state_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_sync_error_monitor.sv
// Self-checking bench: a wide-counter and a 4-bit-counter monitor share stimulus
// and are compared against a behavioural model of the checking rules.
module tb_sync_error_monitor;

  logic       clk = 1'b0;
  logic       rst, sample_valid, run_en, clear;
  logic [3:0] sample, cfg_delta;
  logic [2:0] sel;
  logic [7:0] rd_a, rd_b;
  logic       pulse_a, pulse_b, halted_a, halted_b;
  logic [1:0] state_a, state_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_error_monitor #(.W(4), .CW(16)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .cfg_delta(cfg_delta), .run_en(run_en), .clear(clear), .sel(sel),
    .rd_data(rd_a), .err_pulse(pulse_a), .state(state_a), .halted(halted_a)
  );

  sync_error_monitor #(.W(4), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .cfg_delta(cfg_delta), .run_en(run_en), .clear(clear), .sel(sel),
    .rd_data(rd_b), .err_pulse(pulse_b), .state(state_b), .halted(halted_b)
  );

  // Reference model, one entry per instance; mode 0..3 = idle/seed/run/halt.
  int cmax[2] = '{65535, 15};
  int m_scnt[2], m_ecnt[2], m_burst[2], m_maxb[2];
  int m_prev[2], m_lb[2], m_le[2], m_mode[2];
  bit m_pulse[2];

  task automatic model_edge(input bit v, input int s, input bit re, input bit clr, input bit rs);
    int e;
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 1'b0;
      if (rs || clr) begin
        m_scnt[i] = 0; m_ecnt[i] = 0; m_burst[i] = 0; m_maxb[i] = 0;
        m_prev[i] = 0; m_lb[i] = 0; m_le[i] = 0; m_mode[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (re) m_mode[i] = 1;
      end else if (m_mode[i] == 1) begin
        if (!re) m_mode[i] = 0;
        else if (v) begin
          m_prev[i] = s;
          if (m_scnt[i] < cmax[i]) m_scnt[i]++;
          m_mode[i] = 2;
        end
      end else if (m_mode[i] == 2) begin
        if (!re) m_mode[i] = 0;
        else if (v) begin
          e = (m_prev[i] + int'(cfg_delta)) % 16;
          if (m_scnt[i] < cmax[i]) m_scnt[i]++;
          if (s != e) begin
            if (m_ecnt[i] < cmax[i]) m_ecnt[i]++;
            m_lb[i] = s; m_le[i] = e;
            if (m_burst[i] < 255) m_burst[i]++;
            m_pulse[i] = 1'b1;
          end else begin
            m_burst[i] = 0;
          end
          if (m_burst[i] > m_maxb[i]) m_maxb[i] = m_burst[i];
          m_prev[i] = s;
          if (m_scnt[i] == cmax[i]) m_mode[i] = 3;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_rd(input int i, input int k);
    int v;
    case (k)
      0: v = m_scnt[i] % 256;
      1: v = (m_scnt[i] / 256) % 256;
      2: v = m_ecnt[i] % 256;
      3: v = (m_ecnt[i] / 256) % 256;
      4: v = m_le[i] * 16 + m_lb[i];
      5: v = m_maxb[i];
      6: v = m_mode[i] * 4 + ((m_mode[i] == 3) ? 2 : 0) + (run_en ? 1 : 0);
      default: v = m_prev[i];
    endcase
    return 8'(v);
  endfunction

  task automatic step(input bit v, input int s, input bit clr = 1'b0, input bit rs = 1'b0);
    sample_valid = v;
    sample       = 4'(s);
    clear        = clr;
    rst          = rs;
    @(posedge clk);
    model_edge(v, s, run_en, clr, rs);
    #1;
  endtask

  task automatic read_sel(input int k, output logic [7:0] a, output logic [7:0] b);
    sel = 3'(k);
    step(1'b0, 0);
    a = rd_a;
    b = rd_b;
  endtask

  task automatic test_reset();
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    n_run++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_a); end
    n_run++; if (halted_a !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted_a); end
    n_run++; if (pulse_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", pulse_a); end
    n_run++; if (rd_a !== 8'h00) begin n_fail++; $display("FAIL reset_rd got %h want 00", rd_a); end
    n_run++; if (rd_b !== 8'h00 || state_b !== 2'd0) begin
      n_fail++; $display("FAIL reset_b got rd=%h state=%0d want 00/0", rd_b, state_b);
    end
    step(1'b0, 0);
  endtask

  task automatic test_clean();
    logic [7:0] ra, rb;
    int pulses = 0;
    cfg_delta = 4'd1;
    run_en = 1'b1;
    step(1'b0, 0);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, i % 16);
      if (pulse_a) pulses++;
      n_run++; if (pulse_a !== m_pulse[0]) begin n_fail++; $display("FAIL clean_pulse[%0d] got %b want %b", i, pulse_a, m_pulse[0]); end
    end
    n_run++; if (pulses != 0) begin n_fail++; $display("FAIL clean_pulse_count got %0d want 0", pulses); end
    read_sel(0, ra, rb);
    n_run++; if (ra !== 8'd18 || ra !== exp_rd(0, 0)) begin n_fail++; $display("FAIL clean_scnt got %0d want 18", ra); end
    n_run++; if (rb !== 8'd15) begin n_fail++; $display("FAIL clean_scnt_b got %0d want 15", rb); end
    read_sel(2, ra, rb);
    n_run++; if (ra !== 8'd0) begin n_fail++; $display("FAIL clean_ecnt got %0d want 0", ra); end
    read_sel(5, ra, rb);
    n_run++; if (ra !== 8'd0) begin n_fail++; $display("FAIL clean_maxb got %0d want 0", ra); end
    read_sel(6, ra, rb);
    n_run++; if (ra !== exp_rd(0, 6) || rb !== exp_rd(1, 6)) begin
      n_fail++; $display("FAIL clean_status got %h/%h want %h/%h", ra, rb, exp_rd(0, 6), exp_rd(1, 6));
    end
  endtask

  task automatic test_glitch();
    logic [7:0] ra, rb;
    int seq[5] = '{3, 4, 9, 6, 7};
    bit want[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    cfg_delta = 4'd1;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i]);
      n_run++; if (pulse_a !== want[i] || pulse_a !== m_pulse[0]) begin
        n_fail++; $display("FAIL glitch_pulse[%0d] got %b want %b", i, pulse_a, want[i]);
      end
    end
    read_sel(2, ra, rb);
    n_run++; if (ra !== 8'd2) begin n_fail++; $display("FAIL glitch_ecnt got %0d want 2", ra); end
    read_sel(4, ra, rb);
    n_run++; if (ra !== 8'hA6) begin n_fail++; $display("FAIL glitch_pair got %h want a6", ra); end
    read_sel(5, ra, rb);
    n_run++; if (ra !== exp_rd(0, 5)) begin n_fail++; $display("FAIL glitch_maxb got %0d want %0d", ra, exp_rd(0, 5)); end
  endtask

  task automatic test_burst();
    logic [7:0] ra, rb;
    int seq[6] = '{0, 2, 5, 5, 5, 7};
    cfg_delta = 4'd2;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i]);
      n_run++; if (pulse_a !== m_pulse[0]) begin n_fail++; $display("FAIL burst_pulse[%0d] got %b want %b", i, pulse_a, m_pulse[0]); end
    end
    read_sel(4, ra, rb);
    n_run++; if (ra !== 8'h75) begin n_fail++; $display("FAIL burst_pair got %h want 75", ra); end
    read_sel(2, ra, rb);
    n_run++; if (ra !== 8'd3) begin n_fail++; $display("FAIL burst_ecnt got %0d want 3", ra); end
    read_sel(5, ra, rb);
    n_run++; if (ra !== 8'd3) begin n_fail++; $display("FAIL burst_maxb got %0d want 3", ra); end
  endtask

  task automatic test_saturation();
    logic [7:0] ra, rb;
    cfg_delta = 4'd1;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b1, i % 16);
    n_run++; if (state_b !== 2'd3 || halted_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_halt got state=%0d halted=%b want 3/1", state_b, halted_b);
    end
    read_sel(0, ra, rb);
    n_run++; if (rb !== 8'd15) begin n_fail++; $display("FAIL sat_scnt got %0d want 15", rb); end
    read_sel(1, ra, rb);
    n_run++; if (rb !== 8'd0) begin n_fail++; $display("FAIL sat_scnt_hi got %0d want 0", rb); end
    for (int i = 0; i < 6; i++) step(1'b1, $urandom_range(0, 15));
    for (int k = 0; k < 8; k++) begin
      read_sel(k, ra, rb);
      n_run++; if (rb !== exp_rd(1, k)) begin n_fail++; $display("FAIL sat_hold sel%0d got %h want %h", k, rb, exp_rd(1, k)); end
    end
    n_run++; if (state_b !== 2'd3) begin n_fail++; $display("FAIL sat_stay got %0d want 3", state_b); end
    step(1'b0, 0, 1'b1);
    n_run++; if (state_b !== 2'd0 || halted_b !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear_state got %0d/%b want 0/0", state_b, halted_b);
    end
    read_sel(0, ra, rb);
    n_run++; if (rb !== 8'd0) begin n_fail++; $display("FAIL sat_clear_scnt got %0d want 0", rb); end
    read_sel(2, ra, rb);
    n_run++; if (rb !== 8'd0) begin n_fail++; $display("FAIL sat_clear_ecnt got %0d want 0", rb); end
  endtask

  task automatic test_races();
    logic [7:0] ra, rb;
    cfg_delta = 4'd1;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0);
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b1, 9, 1'b1);
    n_run++; if (pulse_a !== 1'b0) begin n_fail++; $display("FAIL race_clear_pulse got %b want 0", pulse_a); end
    n_run++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL race_clear_state got %0d want 0", state_a); end
    read_sel(0, ra, rb);
    n_run++; if (ra !== 8'd0) begin n_fail++; $display("FAIL race_clear_scnt got %0d want 0", ra); end
    read_sel(2, ra, rb);
    n_run++; if (ra !== 8'd0) begin n_fail++; $display("FAIL race_clear_ecnt got %0d want 0", ra); end
    // Drop enable with a sample pending, then re-seed on a discontinuous value.
    step(1'b1, 5);
    step(1'b1, 6);
    run_en = 1'b0;
    step(1'b1, 7);
    run_en = 1'b1;
    step(1'b0, 0);
    step(1'b1, 12);
    n_run++; if (pulse_a !== 1'b0) begin n_fail++; $display("FAIL reseed_pulse got %b want 0", pulse_a); end
    step(1'b1, 13);
    n_run++; if (pulse_a !== 1'b0) begin n_fail++; $display("FAIL reseed_next_pulse got %b want 0", pulse_a); end
    read_sel(2, ra, rb);
    n_run++; if (ra !== 8'd0) begin n_fail++; $display("FAIL reseed_ecnt got %0d want 0", ra); end
    read_sel(0, ra, rb);
    n_run++; if (ra !== exp_rd(0, 0)) begin n_fail++; $display("FAIL reseed_scnt got %0d want %0d", ra, exp_rd(0, 0)); end
    read_sel(7, ra, rb);
    n_run++; if (ra !== 8'd13) begin n_fail++; $display("FAIL reseed_prev got %0d want 13", ra); end
    // Reset during RUN with a mismatching sample on the same edge.
    step(1'b1, 3, 1'b0, 1'b1);
    n_run++; if (pulse_a !== 1'b0 || state_a !== 2'd0 || halted_a !== 1'b0 || rd_a !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_run got pulse=%b state=%0d halted=%b rd=%h want all 0", pulse_a, state_a, halted_a, rd_a);
    end
    step(1'b0, 0);
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    int s;
    cfg_delta = 4'($urandom_range(0, 15));
    step(1'b0, 0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 3) run_en = ~run_en;
      if ($urandom_range(0, 99) < 85) s = (m_prev[0] + int'(cfg_delta)) % 16;
      else s = $urandom_range(0, 15);
      step($urandom_range(0, 99) < 70, s, $urandom_range(0, 199) == 0);
      n_run++; if (pulse_a !== m_pulse[0] || pulse_b !== m_pulse[1]) begin
        n_fail++; $display("FAIL rand_pulse[%0d] got %b/%b want %b/%b", n, pulse_a, pulse_b, m_pulse[0], m_pulse[1]);
      end
      n_run++; if (state_a !== 2'(m_mode[0]) || state_b !== 2'(m_mode[1])) begin
        n_fail++; $display("FAIL rand_state[%0d] got %0d/%0d want %0d/%0d", n, state_a, state_b, m_mode[0], m_mode[1]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      read_sel(k, ra, rb);
      n_run++; if (ra !== exp_rd(0, k)) begin n_fail++; $display("FAIL rand_rd_a sel%0d got %h want %h", k, ra, exp_rd(0, k)); end
      n_run++; if (rb !== exp_rd(1, k)) begin n_fail++; $display("FAIL rand_rd_b sel%0d got %h want %h", k, rb, exp_rd(1, k)); end
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; run_en = 1'b0; clear = 1'b0;
    sample = 4'd0; cfg_delta = 4'd1; sel = 3'd0;
    test_reset();
    test_clean();
    test_glitch();
    test_burst();
    test_saturation();
    test_races();
    run_en = 1'b1;
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
